// File: rtl/chnl_rx_unpack.sv
// chnl_rx_unpack
// Receives one Riffa RX channel transaction at a time, keeps only the whole
// CHNL_ALIGN-dword records of each transaction, buffers the kept beats in a
// small FIFO and repacks them into RX_WIDTH-bit words on a valid/ready stream.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   CHNL_RX_CLK         channel clock, driven by clk
//   CHNL_RX / _ACK      transaction request / one-cycle registered acknowledge
//   CHNL_RX_LEN         transaction length in dwords (LAST and OFF are ignored)
//   CHNL_RX_DATA/_VALID/_REN  beat handshake, a beat moves on VALID && REN
//   o_val/o_rdy/o_data  repacked output stream, lowest GCD slice first
//   o_err               one-cycle pulse when LEN is not a whole number of records
//   o_busy              high while a transaction is in progress
module chnl_rx_unpack #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int RX_WIDTH         = 32,
  parameter int GCD              = 32,
  parameter int CHNL_ALIGN       = 4,
  parameter int FIFO_DEPTH       = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic                        o_val,
  input  logic                        o_rdy,
  output logic [RX_WIDTH-1:0]         o_data,
  output logic                        o_err,
  output logic                        o_busy
);

  localparam int DPB   = C_PCI_DATA_WIDTH / 32;   // dwords per beat
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IN_S  = C_PCI_DATA_WIDTH / GCD;  // slices per beat
  localparam int OUT_S = RX_WIDTH / GCD;          // slices per output word
  localparam int CAP   = IN_S + OUT_S;            // repacker capacity in slices
  localparam int BW    = CAP * GCD;
  localparam int CW    = $clog2(2 * CAP + 1);

  localparam logic [AW:0]   FIFO_LIMIT = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] IN_C       = CW'(IN_S);
  localparam logic [CW-1:0] OUT_C      = CW'(OUT_S);
  localparam logic [CW-1:0] CAP_C      = CW'(CAP);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RECV} state_t;

  state_t state, state_next;
  logic   latch;
  logic   consume;
  logic   fifo_wr;
  logic   fifo_rd;

  logic [31:0] total_calc, kept_calc, len_rem;
  logic [32:0] len_ext;
  logic [31:0] remain_q, keep_left_q;

  logic [C_PCI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 fifo_cnt;
  logic [C_PCI_DATA_WIDTH-1:0] fifo_rd_data;

  logic [BW-1:0] pack_q, pack_after, pack_next;
  logic [CW-1:0] sc_q, sc_after, sc_next;
  logic          pop;

  logic unused_inputs;
  assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF};

  assign CHNL_RX_CLK = clk;

  // Beat counts are computed in 33 bits so a LEN near 2^32 cannot wrap
  // while rounding up to whole beats.
  assign len_ext    = {1'b0, CHNL_RX_LEN};
  assign total_calc = 32'((len_ext + 33'(DPB - 1)) / 33'(DPB));
  assign len_rem    = CHNL_RX_LEN % 32'(CHNL_ALIGN);
  assign kept_calc  = (CHNL_RX_LEN - len_rem) / 32'(DPB);

  // REN depends only on registered state and occupancy; the one-slot
  // margin keeps a beat in flight from ever overflowing the FIFO.
  assign CHNL_RX_DATA_REN = (state == S_RECV) && (fifo_cnt < FIFO_LIMIT);
  assign consume          = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
  assign fifo_wr          = consume && (keep_left_q != 32'd0);
  assign o_busy           = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (CHNL_RX) begin
          state_next = S_ACK;
          latch      = 1'b1;
        end
      end
      S_ACK:  state_next = (remain_q == 32'd0) ? S_IDLE : S_RECV;
      S_RECV: begin
        if (consume && (remain_q == 32'd1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ACK is registered from the next state so it is high exactly in S_ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CHNL_RX_ACK <= 1'b0;
      o_err       <= 1'b0;
      remain_q    <= '0;
      keep_left_q <= '0;
    end else begin
      CHNL_RX_ACK <= (state_next == S_ACK);
      o_err       <= latch && (len_rem != 32'd0);
      if (latch) begin
        remain_q    <= total_calc;
        keep_left_q <= kept_calc;
      end else if (consume) begin
        if (remain_q != 32'd0)    remain_q    <= remain_q - 32'd1;
        if (keep_left_q != 32'd0) keep_left_q <= keep_left_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= CHNL_RX_DATA;
  end

  assign fifo_rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Repacker: a slice buffer that drains OUT_S slices from the bottom and
  // appends IN_S slices above the remaining ones. Refilling after a pop in
  // the same cycle sustains one beat per cycle.
  always_comb begin
    pop        = o_val && o_rdy;
    sc_after   = sc_q;
    pack_after = pack_q;
    if (pop) begin
      sc_after   = sc_q - OUT_C;
      pack_after = pack_q >> RX_WIDTH;
    end
    fifo_rd   = (fifo_cnt != '0) && ((sc_after + IN_C) <= CAP_C);
    sc_next   = sc_after;
    pack_next = pack_after;
    if (fifo_rd) begin
      sc_next   = sc_after + IN_C;
      pack_next = pack_after | (BW'(fifo_rd_data) << (int'(sc_after) * GCD));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q <= '0;
      sc_q   <= '0;
    end else begin
      pack_q <= pack_next;
      sc_q   <= sc_next;
    end
  end

  assign o_val  = (sc_q >= OUT_C);
  assign o_data = pack_q[RX_WIDTH-1:0];

endmodule
